// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int          INST_ADDR_WIDTH = 32;
    localparam int          INST_WIDTH      = 32;
    localparam logic [31:0] RESET_PC_DEF    = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } if_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter with next-PC mux: hold, sequential +4 (wrapping) or word-aligned redirect.
module inst_fetch_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  pc_sel_e           sel_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_INC:   pc_d = pc_q + ADDR_W'(4);
            PC_REDIR: pc_d = redirect_pc_i & ~ADDR_W'(3);
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: one outstanding imem read, registered hand-off to decode,
// redirect squash via a drop flag, and a sticky halt on ebreak.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_WIDTH,
    parameter int                INST_W   = INST_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              halt_i,
    output logic              halted_o
);

    if_state_e         state_q, state_d;
    logic              drop_q, drop_d;
    logic              latch;
    pc_sel_e           pc_sel;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_out_q;
    logic [INST_W-1:0] inst_q;
    logic              req_fire, consume;

    inst_fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk           (clk),
        .rst           (rst),
        .sel_i         (pc_sel),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc)
    );

    assign imem_req_valid = (state_q == S_REQ) & ~rst;
    assign imem_req_addr  = pc;
    assign id_valid_o     = (state_q == S_HOLD);
    assign halted_o       = (state_q == S_HALT);
    assign pc_o           = pc_out_q;
    assign inst_o         = inst_q;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign consume  = id_valid_o & id_ready_i;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        pc_sel  = PC_HOLD;
        latch   = 1'b0;
        case (state_q)
            S_REQ: begin
                if (redirect_i) pc_sel = PC_REDIR;
                if (req_fire) begin
                    state_d = S_WAIT;
                    drop_d  = redirect_i;
                end
            end
            S_WAIT: begin
                if (redirect_i) pc_sel = PC_REDIR;
                if (imem_resp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_i) begin
                        state_d = S_REQ;
                    end else begin
                        latch   = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                // A consumed ebreak wins over any redirect in the same cycle.
                if (consume && halt_i) begin
                    state_d = S_HALT;
                end else if (redirect_i) begin
                    pc_sel  = PC_REDIR;
                    state_d = S_REQ;
                end else if (consume) begin
                    pc_sel  = PC_INC;
                    state_d = S_REQ;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            drop_q   <= 1'b0;
            pc_out_q <= RESET_PC;
            inst_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (latch) begin
                pc_out_q <= pc;
                inst_q   <= imem_resp_data;
            end
        end
    end

endmodule
